// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access controller:
// load/store aluop codes, bus widths, the access FSM state type and
// small op-classification helpers used by the controller and lane aligner.
package mem_access_ctrl_pkg;

    localparam int          RegBus     = 32;
    localparam int          RegAddrBus = 5;
    localparam logic [31:0] ZeroWord   = 32'h0000_0000;

    localparam logic [7:0] EXE_LB_OP  = 8'hE0;
    localparam logic [7:0] EXE_LH_OP  = 8'hE1;
    localparam logic [7:0] EXE_LW_OP  = 8'hE3;
    localparam logic [7:0] EXE_LBU_OP = 8'hE4;
    localparam logic [7:0] EXE_LHU_OP = 8'hE5;
    localparam logic [7:0] EXE_SB_OP  = 8'hE8;
    localparam logic [7:0] EXE_SH_OP  = 8'hE9;
    localparam logic [7:0] EXE_SW_OP  = 8'hEB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } mem_state_e;

    function automatic logic is_load_op(input logic [7:0] op);
        return (op == EXE_LB_OP)  || (op == EXE_LH_OP)  || (op == EXE_LW_OP) ||
               (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
    endfunction

    function automatic logic is_store_op(input logic [7:0] op);
        return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
    endfunction

    // Halfwords must sit on even addresses, words on multiples of four.
    function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
        logic is_half;
        logic is_word;
        is_half = (op == EXE_LH_OP) || (op == EXE_LHU_OP) || (op == EXE_SH_OP);
        is_word = (op == EXE_LW_OP) || (op == EXE_SW_OP);
        return (is_half && addr_lo[0]) || (is_word && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// mem_lane_align: combinational big-endian lane logic.
//   aluop      : load/store op code
//   addr_lo    : byte offset within the word
//   store_data : rt operand, replicated onto all lanes for stores
//   load_raw   : word returned by the RAM
//   sel        : byte-lane enables, bit 3 = bits 31:24
//   store_rep  : replicated store data
//   load_ext   : extracted and sign/zero-extended load result
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [7:0]        aluop,
    input  logic [1:0]        addr_lo,
    input  logic [RegBus-1:0] store_data,
    input  logic [RegBus-1:0] load_raw,
    output logic [3:0]        sel,
    output logic [RegBus-1:0] store_rep,
    output logic [RegBus-1:0] load_ext
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can infer a latch.
    always_comb begin
        sel       = 4'b0000;
        store_rep = ZeroWord;
        load_ext  = ZeroWord;
        byte_v    = 8'h00;
        half_v    = 16'h0000;

        // Offset 00 is the most significant byte (big-endian).
        case (addr_lo)
            2'b00:   byte_v = load_raw[31:24];
            2'b01:   byte_v = load_raw[23:16];
            2'b10:   byte_v = load_raw[15:8];
            default: byte_v = load_raw[7:0];
        endcase
        half_v = addr_lo[1] ? load_raw[15:0] : load_raw[31:16];

        case (aluop)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: sel = 4'b1000 >> addr_lo;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: sel = addr_lo[1] ? 4'b0011 : 4'b1100;
            EXE_LW_OP, EXE_SW_OP:             sel = 4'b1111;
            default:                          sel = 4'b0000;
        endcase

        case (aluop)
            EXE_SB_OP: store_rep = {4{store_data[7:0]}};
            EXE_SH_OP: store_rep = {2{store_data[15:0]}};
            EXE_SW_OP: store_rep = store_data;
            default:   store_rep = ZeroWord;
        endcase

        case (aluop)
            EXE_LB_OP:  load_ext = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: load_ext = {24'h000000, byte_v};
            EXE_LH_OP:  load_ext = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: load_ext = {16'h0000, half_v};
            EXE_LW_OP:  load_ext = load_raw;
            default:    load_ext = ZeroWord;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller.
// Issues one req/gnt + rvalid bus access per load/store, stalls the pipeline
// until it completes, and presents the write-back triple for MEM/WB.
//   mem_*_i       : operation, address and operands from EX/MEM
//   wd_o/wreg_o/wdata_o : write-back triple to MEM/WB
//   stallreq      : pipeline hold request
//   addr_err      : one-cycle pulse (DONE) on a misaligned access
//   bus_err       : one-cycle pulse (DONE) on access timeout
//   ram_*         : data-RAM request bus (outputs) and response (inputs)
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            mem_aluop_i,
    input  logic [RegBus-1:0]     mem_addr_i,
    input  logic [RegBus-1:0]     mem_reg2_i,
    input  logic [RegAddrBus-1:0] mem_wd_i,
    input  logic                  mem_wreg_i,
    input  logic [RegBus-1:0]     mem_wdata_i,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     wdata_o,
    output logic                  stallreq,
    output logic                  addr_err,
    output logic                  bus_err,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [RegBus-1:0]     ram_addr,
    output logic [3:0]            ram_sel,
    output logic [RegBus-1:0]     ram_wdata,
    input  logic                  ram_gnt,
    input  logic                  ram_rvalid,
    input  logic [RegBus-1:0]     ram_rdata
);

    mem_state_e        state;
    logic [7:0]        cnt;
    logic [RegBus-1:0] load_q;
    logic              addr_err_q;
    logic              bus_err_q;

    logic              is_load;
    logic              is_mem;
    logic              misaligned;
    logic              timeout_hit;
    logic [3:0]        sel_w;
    logic [RegBus-1:0] store_rep_w;
    logic [RegBus-1:0] load_ext_w;

    assign is_load     = is_load_op(mem_aluop_i);
    assign is_mem      = is_load || is_store_op(mem_aluop_i);
    assign misaligned  = is_misaligned(mem_aluop_i, mem_addr_i[1:0]);
    // The counter reaches TIMEOUT on the edge that leaves REQ/RESP, so at most
    // TIMEOUT cycles are spent waiting; a grant or rvalid in that last cycle wins.
    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

    mem_lane_align u_lane (
        .aluop      (mem_aluop_i),
        .addr_lo    (mem_addr_i[1:0]),
        .store_data (mem_reg2_i),
        .load_raw   (ram_rdata),
        .sel        (sel_w),
        .store_rep  (store_rep_w),
        .load_ext   (load_ext_w)
    );

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= 8'd0;
            load_q     <= ZeroWord;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt        <= 8'd0;
                    addr_err_q <= 1'b0;
                    bus_err_q  <= 1'b0;
                    if (is_mem) begin
                        load_q <= ZeroWord;
                        if (misaligned) begin
                            addr_err_q <= 1'b1;
                            state      <= ST_DONE;
                        end else if (ram_gnt) begin
                            state <= is_load ? ST_RESP : ST_DONE;
                        end else begin
                            state <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    cnt <= cnt + 8'd1;
                    if (ram_gnt) begin
                        state <= is_load ? ST_RESP : ST_DONE;
                    end else if (timeout_hit) begin
                        bus_err_q <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_RESP: begin
                    cnt <= cnt + 8'd1;
                    if (ram_rvalid) begin
                        load_q <= load_ext_w;
                        state  <= ST_DONE;
                    end else if (timeout_hit) begin
                        bus_err_q <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs respond combinationally so a request can go out in the same cycle
    // the op arrives; everything is forced low while rst is held.
    always_comb begin
        wd_o      = '0;
        wreg_o    = 1'b0;
        wdata_o   = ZeroWord;
        stallreq  = 1'b0;
        addr_err  = 1'b0;
        bus_err   = 1'b0;
        ram_req   = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = ZeroWord;
        ram_sel   = 4'b0000;
        ram_wdata = ZeroWord;

        if (!rst) begin
            wd_o = mem_wd_i;
            case (state)
                ST_IDLE: begin
                    if (is_mem) begin
                        stallreq = 1'b1;
                        ram_req  = !misaligned;
                    end else begin
                        wreg_o  = mem_wreg_i;
                        wdata_o = mem_wdata_i;
                    end
                end
                ST_REQ: begin
                    stallreq = 1'b1;
                    ram_req  = 1'b1;
                end
                ST_RESP: stallreq = 1'b1;
                default: begin
                    addr_err = addr_err_q;
                    bus_err  = bus_err_q;
                    wreg_o   = mem_wreg_i && !addr_err_q && !bus_err_q;
                    if (bus_err_q)    wdata_o = ZeroWord;
                    else if (is_load) wdata_o = load_q;
                    else              wdata_o = mem_wdata_i;
                end
            endcase

            if (ram_req) begin
                ram_we    = !is_load;
                ram_addr  = {mem_addr_i[31:2], 2'b00};
                ram_sel   = sel_w;
                ram_wdata = store_rep_w;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl (TIMEOUT = 4). Each op pushes its
// expected outcome to a scoreboard queue; the entry is popped and compared
// when the DUT drops stallreq (DONE, or pass-through for non-memory ops).
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  mem_aluop_i;
    logic [31:0] mem_addr_i, mem_reg2_i, mem_wdata_i;
    logic [4:0]  mem_wd_i;
    logic        mem_wreg_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq, addr_err, bus_err;
    logic        ram_req, ram_we;
    logic [31:0] ram_addr, ram_wdata;
    logic [3:0]  ram_sel;
    logic        ram_gnt, ram_rvalid;
    logic [31:0] ram_rdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
        .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq(stallreq),
        .addr_err(addr_err), .bus_err(bus_err),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
        .ram_wdata(ram_wdata), .ram_gnt(ram_gnt), .ram_rvalid(ram_rvalid),
        .ram_rdata(ram_rdata)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] bus_wdata;
        int          stall;
        logic        wreg;
        logic        chk_wdata;
        logic [31:0] wdata;
        logic        aerr;
        logic        berr;
        logic [4:0]  wd;
    } exp_t;

    exp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model of the lane behaviour, written with shifts.
    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [1:0] off);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 4'b0001 << (3 - int'(off));
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return (off == 2'b00) ? 4'b1100 : 4'b0011;
            default:                          return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_store(input logic [7:0] op, input logic [31:0] rt);
        logic [31:0] b;
        logic [31:0] h;
        b = rt & 32'hFF;
        h = rt & 32'hFFFF;
        case (op)
            EXE_SB_OP: return b | (b << 8) | (b << 16) | (b << 24);
            EXE_SH_OP: return h | (h << 16);
            default:   return rt;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [1:0] off,
                                           input logic [31:0] d);
        logic [31:0] sb;
        logic [31:0] sh;
        sb = (d >> (8 * (3 - int'(off)))) & 32'hFF;
        sh = (d >> ((off == 2'b00) ? 16 : 0)) & 32'hFFFF;
        case (op)
            EXE_LB_OP:  return (sb >= 32'h80)   ? (sb | 32'hFFFF_FF00) : sb;
            EXE_LBU_OP: return sb;
            EXE_LH_OP:  return (sh >= 32'h8000) ? (sh | 32'hFFFF_0000) : sh;
            EXE_LHU_OP: return sh;
            default:    return d;
        endcase
    endfunction

    // Drive one op; the bus grants after g request cycles and returns rvalid
    // r cycles after the grant. Big g/r values provoke a timeout.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] rdata,
                          input logic [31:0] alu, input logic wreg_in,
                          input int g, input int r);
        exp_t e;
        exp_t p;
        logic ld, mem, mis, tmo;
        int   sum;
        int   req_n = 0;
        int   resp_n = 0;
        int   stalls = 0;
        int   pulses = 0;
        logic granted = 1'b0;
        logic was_granted;
        logic saw_req = 1'b0;
        logic done = 1'b0;

        ld  = (op == EXE_LB_OP) || (op == EXE_LH_OP) || (op == EXE_LW_OP) ||
              (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
        mem = ld || (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
        mis = mem && (((op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) && addr[0]) ||
                      ((op == EXE_LW_OP || op == EXE_SW_OP) && addr[1:0] != 2'b00));
        sum = g + (ld ? r + 1 : 0);
        tmo = mem && !mis && (sum > TO);

        e.req       = mem && !mis;
        e.addr      = addr & 32'hFFFF_FFFC;
        e.we        = !ld;
        e.sel       = m_sel(op, addr[1:0]);
        e.bus_wdata = m_store(op, rt);
        e.stall     = !mem ? 0 : mis ? 1 : tmo ? 1 + TO : 1 + sum;
        e.wreg      = (mem && (mis || tmo)) ? 1'b0 : wreg_in;
        e.chk_wdata = !mem || (ld && !mis) || tmo;
        e.wdata     = !mem ? alu : tmo ? 32'h0 : m_load(op, addr[1:0], rdata);
        e.aerr      = mis;
        e.berr      = tmo;
        e.wd        = 5'(addr[6:2]) ^ 5'h15;
        sb_q.push_back(e);

        @(posedge clk); #1;
        mem_aluop_i = op;  mem_addr_i = addr; mem_reg2_i = rt;
        mem_wdata_i = alu; mem_wreg_i = wreg_in; mem_wd_i = e.wd;

        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            ram_gnt    = !granted && (req_n == g);
            ram_rvalid = granted && (resp_n == r);
            ram_rdata  = ram_rvalid ? rdata : 32'h5A5A_5A5A;
            #4;
            was_granted = granted;
            if (ram_req) begin
                if (!saw_req) begin
                    check({tag, ".addr"}, ram_addr, e.addr);
                    check({tag, ".sel"}, 32'(ram_sel), 32'(e.sel));
                    check({tag, ".we"}, 32'(ram_we), 32'(e.we));
                    if (!ld) check({tag, ".bus_wdata"}, ram_wdata, e.bus_wdata);
                end
                saw_req = 1'b1;
                if (ram_gnt) granted = 1'b1;
                req_n++;
            end else if (was_granted) begin
                resp_n++;
            end
            if (stallreq) begin
                stalls++;
                pulses += int'(addr_err) + int'(bus_err);
            end else begin
                done = 1'b1;
                p = sb_q.pop_front();
                check({tag, ".req_seen"}, 32'(saw_req), 32'(p.req));
                check({tag, ".stall_cycles"}, stalls, p.stall);
                check({tag, ".early_pulse"}, pulses, 0);
                check({tag, ".wreg"}, 32'(wreg_o), 32'(p.wreg));
                check({tag, ".wd"}, 32'(wd_o), 32'(p.wd));
                check({tag, ".addr_err"}, 32'(addr_err), 32'(p.aerr));
                check({tag, ".bus_err"}, 32'(bus_err), 32'(p.berr));
                if (p.chk_wdata) check({tag, ".wdata"}, wdata_o, p.wdata);
            end
        end
        if (!done) begin
            check({tag, ".done_within_budget"}, 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end
        ram_gnt = 1'b0;
        ram_rvalid = 1'b0;
    endtask

    logic [7:0] ops [8] = '{EXE_LB_OP, EXE_LH_OP, EXE_LW_OP, EXE_LBU_OP,
                            EXE_LHU_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

    initial begin
        rst = 1'b1;
        mem_aluop_i = EXE_LW_OP; mem_addr_i = 32'h0000_1000; mem_reg2_i = 32'hFFFF_FFFF;
        mem_wd_i = 5'd7; mem_wreg_i = 1'b1; mem_wdata_i = 32'hCAFE_F00D;
        ram_gnt = 1'b1; ram_rvalid = 1'b1; ram_rdata = 32'hFFFF_FFFF;

        // Outputs held at zero under reset even with a live op on the inputs.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.ctrl", 32'({stallreq, ram_req, ram_we, wreg_o, addr_err, bus_err}), 32'd0);
        check("rst.wd", 32'(wd_o), 32'd0);
        check("rst.wdata", wdata_o, 32'd0);
        check("rst.ram_addr", ram_addr, 32'd0);
        check("rst.ram_sel", 32'(ram_sel), 32'd0);
        check("rst.ram_wdata", ram_wdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_aluop_i = 8'h20; ram_gnt = 1'b0; ram_rvalid = 1'b0;

        run_op("sw_1004",   EXE_SW_OP,  32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 32'h1111_2222, 1'b1, 0, 0);
        run_op("lb_off3",   EXE_LB_OP,  32'h0000_2003, 32'h0, 32'h1234_56F0, 32'h0, 1'b1, 0, 0);
        run_op("lbu_off3",  EXE_LBU_OP, 32'h0000_2003, 32'h0, 32'h1234_56F0, 32'h0, 1'b1, 0, 0);
        run_op("lhu_gnt3",  EXE_LHU_OP, 32'h0000_3002, 32'h0, 32'hAAAA_8001, 32'h0, 1'b1, 3, 0);
        run_op("lw_mis",    EXE_LW_OP,  32'h0000_4002, 32'h0, 32'h1357_9BDF, 32'h0, 1'b1, 0, 0);
        run_op("sh_mis",    EXE_SH_OP,  32'h0000_4001, 32'hBEEF, 32'h0, 32'h0, 1'b1, 0, 0);
        run_op("lw_tmo",    EXE_LW_OP,  32'h0000_5000, 32'h0, 32'h7777_7777, 32'h0, 1'b1, 0, 100);
        run_op("sw_tmo",    EXE_SW_OP,  32'h0000_5004, 32'h55, 32'h0, 32'h0, 1'b1, 100, 0);
        run_op("alu_pass",  8'h21,      32'h0000_0010, 32'h0, 32'h0, 32'h8765_4321, 1'b1, 0, 0);
        run_op("lw_after",  EXE_LW_OP,  32'h0000_6008, 32'h0, 32'h0BAD_CAFE, 32'h0, 1'b1, 1, 1);

        // Reset while waiting for read data; a stale rvalid must be ignored.
        @(posedge clk); #1;
        mem_aluop_i = EXE_LW_OP; mem_addr_i = 32'h0000_7000; mem_wreg_i = 1'b1;
        ram_gnt = 1'b1;
        #4;
        check("rstmid.req", 32'({ram_req, stallreq}), 32'b11);
        @(posedge clk); #1;
        rst = 1'b1; ram_gnt = 1'b0;
        #4;
        check("rstmid.ctrl", 32'({stallreq, ram_req, wreg_o, addr_err, bus_err}), 32'd0);
        check("rstmid.wdata", wdata_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; mem_aluop_i = 8'h20; mem_wdata_i = 32'h0F0F_0F0F;
        ram_rvalid = 1'b1; ram_rdata = 32'hFFFF_FFFF;
        #4;
        check("rstmid.stale_stall", 32'({stallreq, ram_req, bus_err}), 32'd0);
        check("rstmid.stale_wdata", wdata_o, 32'h0F0F_0F0F);
        @(posedge clk); #1;
        ram_rvalid = 1'b0;
        run_op("lh_post_rst", EXE_LH_OP, 32'h0000_7002, 32'h0, 32'h0000_9234, 32'h0, 1'b1, 0, 0);

        // Sweep every op and offset with small random grant/rvalid delays.
        for (int o = 0; o < 8; o++) begin
            for (int a = 0; a < 4; a++) begin
                int g;
                int r;
                g = int'($urandom_range(0, 1));
                r = int'($urandom_range(0, 1));
                run_op($sformatf("sweep_%02h_%0d", ops[o], a), ops[o],
                       32'h0001_0000 + 32'(16 * o) + 32'(a), $urandom, $urandom,
                       $urandom, 1'($urandom_range(0, 1)), g, r);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
